cacheline_adapter: RTL

- Sits directly downstream of the data cache's dfp port.
- Converts each 256-bit line read or write into a 4-beat, 64-bit burst on the banked-memory (bmem) interface.
- Read bursts: collects four returned beats into one line and pulses dfp_resp.
- Write bursts: serializes the line into four beats and pulses dfp_resp after the last beat is issued.
- One transaction outstanding at a time.

---
 rtl/cacheline_adapter_if.sv | 51 +++++
 rtl/cacheline_adapter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter_if.sv
// Bus bundles for the cache line adapter.
// dfp: the cache drives line requests, the adapter answers.
// bmem: the adapter drives bursts, banked memory answers.

interface cacheline_adapter_dfp_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  // Cache side issues requests
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );

  // Adapter side serves them
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface

interface cacheline_adapter_bmem_if #(
  parameter int BEAT_W = 64
);
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  // Adapter side issues bursts
  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  // Memory side serves them
  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Cache line adapter: turns one 256-bit line read/write from the data
// cache into a 4-beat 64-bit burst on banked memory. One transaction
// is in flight at a time; completion is a one-cycle dfp_resp pulse.

module cacheline_adapter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cacheline_adapter_dfp_if.slave   dfp,
  cacheline_adapter_bmem_if.master bmem
);

  localparam int LINE_W = BEAT_W * BURST_LEN;
  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       addr_reg, addr_next;
  logic [LINE_W-1:0] wline_reg, wline_next;
  logic [LINE_W-1:0] buffer_reg, buffer_next;
  logic [LINE_W-1:0] rdata_hold_reg, rdata_hold_next;

  logic [BEAT_W-1:0]    wbeat [BURST_LEN];
  logic                 beat_hit;
  logic [BURST_LEN-1:0] beat_we;

  logic              bmem_read_int;
  logic              bmem_write_int;
  logic [31:0]       bmem_addr_int;
  logic [BEAT_W-1:0] bmem_wdata_int;
  logic              dfp_resp_int;

  // A returned beat belongs to us only while collecting and only if its
  // tag matches the burst we asked for; stale or foreign beats drop out.
  assign beat_hit = (state_reg == RD_DATA) && bmem.bmem_rvalid &&
                    (bmem.bmem_raddr == addr_reg);

  // Per-beat views: write line split into beats, and assembly buffer
  // slices that load only when their beat index is the one arriving.
  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_beat
    assign wbeat[gi]   = wline_reg[gi*BEAT_W +: BEAT_W];
    assign beat_we[gi] = beat_hit && (cnt_reg == CNT_W'(gi));
    assign buffer_next[gi*BEAT_W +: BEAT_W] =
      beat_we[gi] ? bmem.bmem_rdata : buffer_reg[gi*BEAT_W +: BEAT_W];
  end

  // State, counter and datapath registers; reset abandons any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wline_reg      <= '0;
      buffer_reg     <= '0;
      rdata_hold_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      wline_reg      <= wline_next;
      buffer_reg     <= buffer_next;
      rdata_hold_reg <= rdata_hold_next;
    end
  end

  // Next-state and bus outputs; everything idles to zero by default.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    wline_next      = wline_reg;
    rdata_hold_next = rdata_hold_reg;
    bmem_read_int   = 1'b0;
    bmem_write_int  = 1'b0;
    bmem_addr_int   = '0;
    bmem_wdata_int  = '0;
    dfp_resp_int    = 1'b0;

    case (state_reg)
      IDLE: begin
        // Write wins a tie so a dirty victim leaves before its refill.
        if (dfp.dfp_write) begin
          addr_next  = dfp.dfp_addr;
          wline_next = dfp.dfp_wdata;
          cnt_next   = '0;
          state_next = WR;
        end else if (dfp.dfp_read) begin
          addr_next  = dfp.dfp_addr;
          state_next = RD_REQ;
        end
      end

      RD_REQ: begin
        bmem_read_int = 1'b1;
        bmem_addr_int = addr_reg;
        if (bmem.bmem_ready) begin
          cnt_next   = '0;
          state_next = RD_DATA;
        end
      end

      RD_DATA: begin
        // Gaps between beats are fine; only tagged beats advance.
        if (beat_hit) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end

      WR: begin
        bmem_write_int = 1'b1;
        bmem_addr_int  = addr_reg;
        bmem_wdata_int = wbeat[cnt_reg];
        // Only the first beat waits; once memory takes it, the rest of
        // the burst is guaranteed to be accepted back to back.
        if ((cnt_reg != '0) || bmem.bmem_ready) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        dfp_resp_int    = 1'b1;
        rdata_hold_next = buffer_reg;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bmem.bmem_read  = bmem_read_int;
  assign bmem.bmem_write = bmem_write_int;
  assign bmem.bmem_addr  = bmem_addr_int;
  assign bmem.bmem_wdata = bmem_wdata_int;
  assign dfp.dfp_resp    = dfp_resp_int;
  // The live buffer is shown during the response; otherwise the line from
  // the last completion is held so partial assembly never leaks out.
  assign dfp.dfp_rdata   = (state_reg == DONE) ? buffer_reg : rdata_hold_reg;

  // A read request and a write beat are never driven together.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(bmem_read_int && bmem_write_int));

  // The completion pulse never lasts longer than one cycle.
  assert property (@(posedge clk) disable iff (!rst_n)
                   dfp_resp_int |=> !dfp_resp_int);

endmodule
